// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: size/operation codes, FSM states and
// the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StBeat0,
        StBeat1,
        StDone,
        StHold
    } mau_state_e;

    // Natural alignment: the low address bits covered by the access size must be zero.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
        logic mis;
        unique case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lo[0];
            SZ_W:    mis = |lo[1:0];
            default: mis = |lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed lane(s) of the captured bus data and sign/zero-extends to 64 bits.
module load_extender
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] beat0_i,
    input  logic [31:0] beat1_i,
    output logic [63:0] rdata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sext;

    assign byte_lane = beat0_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = beat0_i[{addr_lo_i[1], 4'b0000} +: 16];
    assign sext      = ~unsigned_i;

    always_comb begin
        rdata_o = '0;
        unique case (size_i)
            SZ_B:    rdata_o = {{56{sext & byte_lane[7]}}, byte_lane};
            SZ_H:    rdata_o = {{48{sext & half_lane[15]}}, half_lane};
            SZ_W:    rdata_o = {{32{sext & beat0_i[31]}}, beat0_i};
            default: rdata_o = {beat1_i, beat0_i};
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Converts one RV64 memory request into one or two 32-bit bus beats and returns
// extended load data.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memory_start,
    input  logic              sel_mem_operation,
    input  logic [1:0]        sel_mem_size,
    input  logic [2:0]        sel_mem_extension,
    input  logic [63:0]       addr,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata,
    output logic              memory_done,
    output logic              misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned AddrW = MEM_AW + 2;

    mau_state_e        state_q, state_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              zext_q, zext_d;
    logic              op_q, op_d;
    logic [31:0]       beat0_q, beat0_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;
    logic [63:0]       ext_rdata;
    logic [31:0]       ext_beat0;
    logic              unused_in;

    assign unused_in = ^{addr[63:AddrW], sel_mem_extension[1:0]};

    // In the single-beat case the result is extended straight from the bus on the ack cycle.
    assign ext_beat0 = (state_q == StBeat0) ? mem_rdata : beat0_q;

    load_extender u_load_extender (
        .size_i     (size_q),
        .unsigned_i (zext_q),
        .addr_lo_i  (addr_q[1:0]),
        .beat0_i    (ext_beat0),
        .beat1_i    (mem_rdata),
        .rdata_o    (ext_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        zext_d  = zext_q;
        op_d    = op_q;
        beat0_d = beat0_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (memory_start) begin
                    addr_d  = addr[AddrW-1:0];
                    wdata_d = wdata;
                    size_d  = sel_mem_size;
                    zext_d  = sel_mem_extension[2];
                    op_d    = sel_mem_operation;
                    if (is_misaligned(sel_mem_size, addr[2:0])) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = StBeat0;
                    end
                end
            end
            StBeat0: begin
                if (mem_ack) begin
                    beat0_d = mem_rdata;
                    if (size_q == SZ_D) begin
                        state_d = StBeat1;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        if (op_q == OP_RD) rdata_d = ext_rdata;
                    end
                end
            end
            StBeat1: begin
                if (mem_ack) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    if (op_q == OP_RD) rdata_d = ext_rdata;
                end
            end
            StDone: state_d = StHold;
            StHold: if (!memory_start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_B;
            zext_q  <= 1'b0;
            op_q    <= OP_RD;
            beat0_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            zext_q  <= zext_d;
            op_q    <= op_d;
            beat0_q <= beat0_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
        end
    end

    assign rdata       = rdata_q;
    assign memory_done = done_q;
    assign misaligned  = mis_q;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        if (state_q == StBeat0) begin
            mem_req  = 1'b1;
            mem_we   = op_q;
            mem_addr = addr_q[AddrW-1:2];
            unique case (size_q)
                SZ_B: begin
                    mem_be    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                SZ_H: begin
                    mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = wdata_q[31:0];
                end
            endcase
        end else if (state_q == StBeat1) begin
            mem_req   = 1'b1;
            mem_we    = op_q;
            mem_addr  = addr_q[AddrW-1:2] + MEM_AW'(1);
            mem_be    = 4'b1111;
            mem_wdata = wdata_q[63:32];
        end
    end

endmodule
